fpu_op_arbiter: RTL and testbench
=================================

Name: fpu_op_arbiter

Overview:
- Shares one floating-point adder (floating_point_add) and one floating-point multiplier (floating_point_multiply) between NUM_REQ requesters, for example several PCPI FPU front-ends.
- Round-robin arbitration issues at most one op per cycle.
- Each accepted op is tagged with its requester ID in a per-unit in-order tag FIFO, so each unit result is routed back to the requester that issued it.
- Sits between the PCPI decode logic and the two arithmetic units.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- DATA_WIDTH, 32, operand and result width (IEEE-754 single precision).
- ID_WIDTH, 3, requester ID width; must satisfy 2**ID_WIDTH >= NUM_REQ.

Ports:
- clkIn  in  1  clock.
- rstIn  in  1  asynchronous active-high reset.
- reqValidIn  in  NUM_REQ  request valid, one bit per requester.
- reqOpIn  in  2*NUM_REQ  op per requester: 00 add, 01 sub, 10 mul, 11 illegal.
- reqAIn  in  DATA_WIDTH*NUM_REQ  operand A per requester.
- reqBIn  in  DATA_WIDTH*NUM_REQ  operand B per requester.
- reqReadyOut  out  NUM_REQ  grant; request accepted when valid && ready.
- respValidOut  out  NUM_REQ  one-cycle result pulse per requester.
- respDataOut  out  DATA_WIDTH*NUM_REQ  result per requester; held until that requester's next response.
- addValidOut  out  1  adder start pulse.
- addAOut  out  DATA_WIDTH  adder operand A.
- addBOut  out  DATA_WIDTH  adder operand B.
- addValidIn  in  1  adder result valid.
- addDataIn  in  DATA_WIDTH  adder result.
- mulValidOut  out  1  multiplier start pulse.
- mulAOut  out  DATA_WIDTH  multiplier operand A.
- mulBOut  out  DATA_WIDTH  multiplier operand B.
- mulValidIn  in  1  multiplier result valid.
- mulDataIn  in  DATA_WIDTH  multiplier result.
- errOut  out  1  sticky error: a unit result arrived while that unit's tag FIFO was empty.

Behaviour:
- Reset (asynchronous): all outputs are 0, busy bits are clear, the round-robin pointer is 0, and both tag FIFOs are empty.
  - Reset mid-operation abandons all in-flight ops; no responses are produced for them.
  - The units share rstIn.
- Busy tracking:
  - Each requester has at most one op outstanding.
  - busy[i] is set on acceptance and cleared in the cycle respValidOut[i] pulses.
  - A requester is eligible when reqValidIn[i] && !busy[i].
- Arbitration:
  - Combinational round-robin starting at the pointer; at most one reqReadyOut bit is high per cycle.
  - On a grant to i, the pointer moves to (i+1) mod NUM_REQ. With no grant, the pointer holds.
  - reqReadyOut may depend on reqValidIn; requesters must not make valid depend on ready.
- Issue, for a request accepted in cycle T:
  - add: addValidOut pulses in T+1 with A, B registered.
  - sub: the same as add, but B is sent with bit 31 inverted.
  - mul: mulValidOut pulses in T+1.
  - The requester ID is pushed into that unit's tag FIFO in T+1.
  - Operand outputs hold their last value when the valid pulse is low.
- Tag FIFOs:
  - One per unit, depth NUM_REQ, pointer wrap at NUM_REQ. This depth cannot overflow because of the busy rule.
  - On a unit valid input, pop the head ID k. In the next cycle, respValidOut[k] = 1 and respDataOut slice k = the unit data.
  - Total latency is unit latency L + 2 cycles from acceptance.
  - If a unit valid input arrives while its FIFO is empty: the result is dropped and errOut is set until reset.
- Simultaneous events:
  - Add and mul results in the same cycle go to different requesters; both are delivered in the same cycle.
  - A push and a pop on the same FIFO in the same cycle are both performed.
- Illegal op 11:
  - Granted normally, consuming the slot; no unit is issued.
  - respValidOut pulses in T+1 with data 0x7FC00000 (canonical NaN).
- A requester whose response pulses in cycle C may be granted again in cycle C.

Decomposition:
- Shared package fpu_pkg holds:
  - op encodings (OP_ADD, OP_SUB, OP_MUL, OP_ILLEGAL);
  - CANONICAL_NAN = 32'h7FC00000;
  - the sign bit index 31.
- One sub-module, fpu_tag_fifo, parameterised by DEPTH and ID_WIDTH, with push/pop/empty/full outputs. It is instantiated twice, once per unit.

Test Plan:
- Bench unit models have fixed latency 3. Operand values: 1.0 = 0x3F800000, 2.0 = 0x40000000, 3.0 = 0x40400000.
- Req0 add 0x3F800000 + 0x40000000 -> addValidOut at T+1; respValidOut[0] at T+5 with 0x40400000.
- Req1 sub 0x40400000, 0x3F800000 -> addBOut = 0xBF800000; resp[1] = 0x40000000.
- Req0 mul and req1 add valid in the same cycle, pointer 0 -> req0 granted at T, req1 granted at T+1, pointer ends at 0; both results routed correctly with no cross-talk.
- Req0 mul 0x40000000 x 0x40400000 and req1 add issued one cycle apart, with unit latencies arranged so both results land in the same cycle -> both respValidOut bits set together; data 0x40C00000 on slice 0.
- Illegal op 11 from req1 -> no unit pulse; resp[1] at T+1 = 0x7FC00000. A spurious addValidIn with an empty FIFO -> errOut = 1, held until reset.
- Assert rstIn while 2 ops are in flight -> all outputs 0 immediately; no responses after release; new requests work.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU op arbiter: op encodings and IEEE-754 single-precision constants.
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_MUL     = 2'b10,
        OP_ILLEGAL = 2'b11
    } fpu_op_e;

    localparam logic [31:0] CANONICAL_NAN = 32'h7FC0_0000;
    localparam int unsigned SIGN_BIT      = 31;

endpackage

// File: rtl/fpu_tag_fifo.sv
// In-order FIFO of requester IDs for one arithmetic unit; the head names the owner of the next
// result that unit returns.
module fpu_tag_fifo #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned ID_WIDTH = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [ID_WIDTH-1:0] push_id_i,
    input  logic                pop_i,
    output logic [ID_WIDTH-1:0] head_id_o,
    output logic                empty_o,
    output logic                full_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [ID_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q;
    logic [PtrW-1:0]     rd_ptr_q;
    logic [CntW-1:0]     count_q;
    logic                do_push;
    logic                do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CntW'(DEPTH));
    assign head_id_o = mem_q[rd_ptr_q];
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_id_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fpu_op_arbiter.sv
// Round-robin arbiter sharing one FP adder and one FP multiplier between NUM_REQ requesters;
// results are routed back through per-unit in-order tag FIFOs.
module fpu_op_arbiter
    import fpu_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 3
) (
    input  logic                          clkIn,
    input  logic                          rstIn,
    input  logic [NUM_REQ-1:0]            reqValidIn,
    input  logic [2*NUM_REQ-1:0]          reqOpIn,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] reqAIn,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] reqBIn,
    output logic [NUM_REQ-1:0]            reqReadyOut,
    output logic [NUM_REQ-1:0]            respValidOut,
    output logic [DATA_WIDTH*NUM_REQ-1:0] respDataOut,
    output logic                          addValidOut,
    output logic [DATA_WIDTH-1:0]         addAOut,
    output logic [DATA_WIDTH-1:0]         addBOut,
    input  logic                          addValidIn,
    input  logic [DATA_WIDTH-1:0]         addDataIn,
    output logic                          mulValidOut,
    output logic [DATA_WIDTH-1:0]         mulAOut,
    output logic [DATA_WIDTH-1:0]         mulBOut,
    input  logic                          mulValidIn,
    input  logic [DATA_WIDTH-1:0]         mulDataIn,
    output logic                          errOut
);

    logic [NUM_REQ-1:0]            busy_q, busy_d;
    logic [ID_WIDTH-1:0]           ptr_q, ptr_d;
    logic                          add_valid_q, add_valid_d;
    logic [DATA_WIDTH-1:0]         add_a_q, add_a_d, add_b_q, add_b_d;
    logic                          mul_valid_q, mul_valid_d;
    logic [DATA_WIDTH-1:0]         mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [NUM_REQ-1:0]            resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH*NUM_REQ-1:0] resp_data_q, resp_data_d;
    logic                          err_q, err_d;

    logic [NUM_REQ-1:0]    elig;
    logic [NUM_REQ-1:0]    ready;
    logic                  grant_valid;
    logic [ID_WIDTH-1:0]   grant_id;
    fpu_op_e               op_g;
    logic [DATA_WIDTH-1:0] a_g, b_g;

    logic                add_push, add_pop, add_empty, add_full;
    logic                mul_push, mul_pop, mul_empty, mul_full;
    logic [ID_WIDTH-1:0] add_head, mul_head;
    logic                unused_full;

    assign elig = reqValidIn & ~busy_q;

    // Search from the pointer outward; the first eligible requester wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        ready       = '0;
        op_g        = OP_ADD;
        a_g         = '0;
        b_g         = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!grant_valid && elig[i] && (i == (32'(ptr_q) + off) % NUM_REQ)) begin
                    grant_valid = 1'b1;
                    grant_id    = ID_WIDTH'(i);
                    ready[i]    = 1'b1;
                    op_g        = fpu_op_e'(reqOpIn[2*i +: 2]);
                    a_g         = reqAIn[DATA_WIDTH*i +: DATA_WIDTH];
                    b_g         = reqBIn[DATA_WIDTH*i +: DATA_WIDTH];
                end
            end
        end
    end

    assign add_push = grant_valid && (op_g == OP_ADD || op_g == OP_SUB);
    assign mul_push = grant_valid && (op_g == OP_MUL);
    assign add_pop  = addValidIn && !add_empty;
    assign mul_pop  = mulValidIn && !mul_empty;

    always_comb begin
        busy_d       = busy_q;
        ptr_d        = ptr_q;
        add_valid_d  = 1'b0;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        mul_valid_d  = 1'b0;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        err_d        = err_q | (addValidIn & add_empty) | (mulValidIn & mul_empty);

        // Busy clears with the registered response so the owner may be granted in that cycle.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (add_pop && add_head == ID_WIDTH'(i)) begin
                resp_valid_d[i]                         = 1'b1;
                resp_data_d[DATA_WIDTH*i +: DATA_WIDTH] = addDataIn;
                busy_d[i]                               = 1'b0;
            end
            if (mul_pop && mul_head == ID_WIDTH'(i)) begin
                resp_valid_d[i]                         = 1'b1;
                resp_data_d[DATA_WIDTH*i +: DATA_WIDTH] = mulDataIn;
                busy_d[i]                               = 1'b0;
            end
        end

        if (grant_valid) begin
            ptr_d = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);
            case (op_g)
                OP_ADD: begin
                    add_valid_d = 1'b1;
                    add_a_d     = a_g;
                    add_b_d     = b_g;
                end
                OP_SUB: begin
                    add_valid_d        = 1'b1;
                    add_a_d            = a_g;
                    add_b_d            = b_g;
                    add_b_d[SIGN_BIT]  = ~b_g[SIGN_BIT];
                end
                OP_MUL: begin
                    mul_valid_d = 1'b1;
                    mul_a_d     = a_g;
                    mul_b_d     = b_g;
                end
                OP_ILLEGAL: ;
                default: ;
            endcase
            // Illegal ops answer immediately with NaN and never occupy a unit.
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (ready[i]) begin
                    if (op_g == OP_ILLEGAL) begin
                        resp_valid_d[i]                         = 1'b1;
                        resp_data_d[DATA_WIDTH*i +: DATA_WIDTH] = DATA_WIDTH'(CANONICAL_NAN);
                    end else begin
                        busy_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            busy_q       <= '0;
            ptr_q        <= '0;
            add_valid_q  <= 1'b0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            mul_valid_q  <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            ptr_q        <= ptr_d;
            add_valid_q  <= add_valid_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            mul_valid_q  <= mul_valid_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            err_q        <= err_d;
        end
    end

    fpu_tag_fifo #(
        .DEPTH    (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_add_tags (
        .clk_i     (clkIn),
        .rst_i     (rstIn),
        .push_i    (add_push),
        .push_id_i (grant_id),
        .pop_i     (add_pop),
        .head_id_o (add_head),
        .empty_o   (add_empty),
        .full_o    (add_full)
    );

    fpu_tag_fifo #(
        .DEPTH    (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_mul_tags (
        .clk_i     (clkIn),
        .rst_i     (rstIn),
        .push_i    (mul_push),
        .push_id_i (grant_id),
        .pop_i     (mul_pop),
        .head_id_o (mul_head),
        .empty_o   (mul_empty),
        .full_o    (mul_full)
    );

    // The busy rule bounds occupancy, so full is never needed here.
    assign unused_full = add_full | mul_full;

    assign reqReadyOut  = ready;
    assign respValidOut = resp_valid_q;
    assign respDataOut  = resp_data_q;
    assign addValidOut  = add_valid_q;
    assign addAOut      = add_a_q;
    assign addBOut      = add_b_q;
    assign mulValidOut  = mul_valid_q;
    assign mulAOut      = mul_a_q;
    assign mulBOut      = mul_b_q;
    assign errOut       = err_q;

endmodule

// File: tb/tb_fpu_op_arbiter.sv
// Scoreboard bench for fpu_op_arbiter with fixed-latency adder/multiplier models.
module tb_fpu_op_arbiter;
    import fpu_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 3;

    localparam logic [31:0] F1   = 32'h3F80_0000;
    localparam logic [31:0] F2   = 32'h4000_0000;
    localparam logic [31:0] F3   = 32'h4040_0000;
    localparam logic [31:0] F6   = 32'h40C0_0000;
    localparam logic [31:0] NEG1 = 32'hBF80_0000;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic              clkIn = 1'b0;
    logic              rstIn;
    logic [NR-1:0]     reqValidIn;
    logic [2*NR-1:0]   reqOpIn;
    logic [DW*NR-1:0]  reqAIn, reqBIn;
    logic [NR-1:0]     reqReadyOut, respValidOut;
    logic [DW*NR-1:0]  respDataOut;
    logic              addValidOut, mulValidOut, addValidIn, mulValidIn, errOut;
    logic [DW-1:0]     addAOut, addBOut, mulAOut, mulBOut, addDataIn, mulDataIn;

    logic [1:0]  r_op [NR];
    logic [31:0] r_a  [NR];
    logic [31:0] r_b  [NR];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   add_lat = 3;
    int   mul_lat = 3;
    int   spur_req = 0;
    int   last_resp [NR];
    int   grant_cyc [NR];
    exp_t exp_q [NR][$];

    always #5 clkIn = ~clkIn;
    always @(posedge clkIn) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            reqOpIn[2*i +: 2] = r_op[i];
            reqAIn[DW*i +: DW] = r_a[i];
            reqBIn[DW*i +: DW] = r_b[i];
        end
    end

    fpu_op_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW)
    ) dut (
        .clkIn        (clkIn),
        .rstIn        (rstIn),
        .reqValidIn   (reqValidIn),
        .reqOpIn      (reqOpIn),
        .reqAIn       (reqAIn),
        .reqBIn       (reqBIn),
        .reqReadyOut  (reqReadyOut),
        .respValidOut (respValidOut),
        .respDataOut  (respDataOut),
        .addValidOut  (addValidOut),
        .addAOut      (addAOut),
        .addBOut      (addBOut),
        .addValidIn   (addValidIn),
        .addDataIn    (addDataIn),
        .mulValidOut  (mulValidOut),
        .mulAOut      (mulAOut),
        .mulBOut      (mulBOut),
        .mulValidIn   (mulValidIn),
        .mulDataIn    (mulDataIn),
        .errOut       (errOut)
    );

    function automatic logic [31:0] unit_add(input logic [31:0] a, input logic [31:0] b);
        if ((a == F1 && b == F2) || (a == F2 && b == F1)) return F3;
        if (a == F3 && b == NEG1) return F2;
        return a ^ b;
    endfunction

    function automatic logic [31:0] unit_mul(input logic [31:0] a, input logic [31:0] b);
        if (a == F1 && b == F2) return F2;
        if (a == F2 && b == F3) return F6;
        return a ^ ~b;
    endfunction

    // Adder/multiplier models: a start seen in cycle c returns its result in cycle c + latency.
    task automatic unit_model();
        exp_t add_pipe[$];
        exp_t mul_pipe[$];
        exp_t e;
        int   spur_done = 0;
        addValidIn = 1'b0;
        mulValidIn = 1'b0;
        addDataIn  = '0;
        mulDataIn  = '0;
        forever begin
            @(negedge clkIn);
            addValidIn = 1'b0;
            mulValidIn = 1'b0;
            if (rstIn) begin
                add_pipe.delete();
                mul_pipe.delete();
                spur_done = spur_req;
            end else begin
                if (addValidOut) add_pipe.push_back('{data: unit_add(addAOut, addBOut),
                                                      due: cyc + add_lat});
                if (mulValidOut) mul_pipe.push_back('{data: unit_mul(mulAOut, mulBOut),
                                                      due: cyc + mul_lat});
                if (add_pipe.size() != 0 && add_pipe[0].due == cyc) begin
                    e          = add_pipe.pop_front();
                    addValidIn = 1'b1;
                    addDataIn  = e.data;
                end
                if (mul_pipe.size() != 0 && mul_pipe[0].due == cyc) begin
                    e          = mul_pipe.pop_front();
                    mulValidIn = 1'b1;
                    mulDataIn  = e.data;
                end
                if (spur_done != spur_req) begin
                    spur_done  = spur_req;
                    addValidIn = 1'b1;
                    addDataIn  = 32'hDEAD_BEEF;
                end
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clkIn);
            if (!rstIn) begin
                for (int i = 0; i < NR; i++) begin
                    if (respValidOut[i]) begin
                        total++;
                        last_resp[i] = cyc;
                        if (exp_q[i].size() == 0) begin
                            bad++;
                            $display("FAIL resp_unexpected[%0d]: got %h at cycle %0d, required none",
                                     i, respDataOut[DW*i +: DW], cyc);
                        end else begin
                            e = exp_q[i].pop_front();
                            if (respDataOut[DW*i +: DW] !== e.data || cyc != e.due) begin
                                bad++;
                                $display("FAIL resp[%0d]: got %h at cycle %0d, required %h at cycle %0d",
                                         i, respDataOut[DW*i +: DW], cyc, e.data, e.due);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        r_op[i]       = op;
        r_a[i]        = a;
        r_b[i]        = b;
        reqValidIn[i] = 1'b1;
    endtask

    task automatic accept(input int i);
        exp_t e;
        grant_cyc[i] = cyc;
        case (r_op[i])
            2'b00:   e = '{data: unit_add(r_a[i], r_b[i]), due: cyc + add_lat + 2};
            2'b01:   e = '{data: unit_add(r_a[i], r_b[i] ^ 32'h8000_0000), due: cyc + add_lat + 2};
            2'b10:   e = '{data: unit_mul(r_a[i], r_b[i]), due: cyc + mul_lat + 2};
            default: e = '{data: CANONICAL_NAN, due: cyc + 1};
        endcase
        exp_q[i].push_back(e);
    endtask

    // Called just after a negedge; returns at the negedge after the last grant.
    task automatic run_reqs();
        logic [NR-1:0] acc;
        int budget = 20;
        while (reqValidIn != '0 && budget > 0) begin
            #1;
            acc = reqValidIn & reqReadyOut;
            total++;
            if ($countones(reqReadyOut) > 1) begin
                bad++;
                $display("FAIL ready_onehot: got %b, required at most one bit", reqReadyOut);
            end
            for (int i = 0; i < NR; i++) if (acc[i]) accept(i);
            @(negedge clkIn);
            reqValidIn = reqValidIn & ~acc;
            budget--;
        end
        if (reqValidIn != '0) begin
            total++;
            bad++;
            $display("FAIL grant_timeout: valid still %b, required all granted", reqValidIn);
            reqValidIn = '0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size()) != 0 && n < 40) begin
            @(negedge clkIn);
            #1;
            n++;
        end
        total++;
        if ((exp_q[0].size() + exp_q[1].size()) != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0",
                     exp_q[0].size() + exp_q[1].size());
            exp_q[0].delete();
            exp_q[1].delete();
        end
        repeat (2) @(negedge clkIn);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clkIn);
        total++;
        if (addValidOut !== 1'b0 || mulValidOut !== 1'b0 || respValidOut !== '0) begin
            bad++;
            $display("FAIL reset_in_valids: got add=%b mul=%b resp=%b, required 0/0/00",
                     addValidOut, mulValidOut, respValidOut);
        end
        rstIn = 1'b0;
        @(negedge clkIn);
        #1;
        total++;
        if (reqReadyOut !== '0 || respDataOut !== '0 || errOut !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_data_err: got %b %h %b, required 00 0 0",
                     reqReadyOut, respDataOut, errOut);
        end
        total++;
        if (addAOut !== '0 || addBOut !== '0 || mulAOut !== '0 || mulBOut !== '0) begin
            bad++;
            $display("FAIL reset_operands: got %h %h %h %h, required all 0",
                     addAOut, addBOut, mulAOut, mulBOut);
        end
    endtask

    task automatic test_add();
        @(negedge clkIn);
        set_req(0, 2'b00, F1, F2);
        run_reqs();
        total++;
        if (addValidOut !== 1'b1 || addAOut !== F1 || addBOut !== F2 || mulValidOut !== 1'b0) begin
            bad++;
            $display("FAIL add_issue: got v=%b a=%h b=%h mv=%b, required 1 %h %h 0",
                     addValidOut, addAOut, addBOut, mulValidOut, F1, F2);
        end
        drain();
        total++;
        if (addValidOut !== 1'b0 || addAOut !== F1 || addBOut !== F2) begin
            bad++;
            $display("FAIL add_hold: got v=%b a=%h b=%h, required 0 %h %h",
                     addValidOut, addAOut, addBOut, F1, F2);
        end
    endtask

    task automatic test_sub();
        @(negedge clkIn);
        set_req(1, 2'b01, F3, F1);
        run_reqs();
        total++;
        if (addValidOut !== 1'b1 || addAOut !== F3 || addBOut !== NEG1) begin
            bad++;
            $display("FAIL sub_issue: got v=%b a=%h b=%h, required 1 %h %h",
                     addValidOut, addAOut, addBOut, F3, NEG1);
        end
        drain();
    endtask

    task automatic test_round_robin();
        @(negedge clkIn);
        set_req(0, 2'b10, F1, F2);
        set_req(1, 2'b00, F1, F2);
        run_reqs();
        total++;
        if (grant_cyc[1] != grant_cyc[0] + 1) begin
            bad++;
            $display("FAIL rr_order: got grants at %0d/%0d, required req1 one cycle after req0",
                     grant_cyc[0], grant_cyc[1]);
        end
        drain();
        @(negedge clkIn);
        set_req(0, 2'b00, F2, F1);
        set_req(1, 2'b10, F1, F2);
        run_reqs();
        total++;
        if (grant_cyc[0] >= grant_cyc[1]) begin
            bad++;
            $display("FAIL rr_pointer_back_to_0: got grants at %0d/%0d, required req0 first",
                     grant_cyc[0], grant_cyc[1]);
        end
        drain();
    endtask

    task automatic test_same_cycle();
        add_lat = 2;
        mul_lat = 3;
        @(negedge clkIn);
        set_req(0, 2'b10, F2, F3);
        set_req(1, 2'b00, F1, F2);
        run_reqs();
        drain();
        total++;
        if (last_resp[0] != last_resp[1]) begin
            bad++;
            $display("FAIL same_cycle_resp: got cycles %0d/%0d, required equal",
                     last_resp[0], last_resp[1]);
        end
        total++;
        if (respDataOut[31:0] !== F6 || respDataOut[63:32] !== F3) begin
            bad++;
            $display("FAIL same_cycle_data_hold: got %h/%h, required %h/%h",
                     respDataOut[31:0], respDataOut[63:32], F6, F3);
        end
        add_lat = 3;
    endtask

    task automatic test_illegal();
        @(negedge clkIn);
        set_req(1, 2'b11, F1, F2);
        run_reqs();
        total++;
        if (addValidOut !== 1'b0 || mulValidOut !== 1'b0 || respValidOut !== 2'b10 ||
            respDataOut[63:32] !== CANONICAL_NAN) begin
            bad++;
            $display("FAIL illegal_resp: got av=%b mv=%b rv=%b d=%h, required 0 0 10 %h",
                     addValidOut, mulValidOut, respValidOut, respDataOut[63:32], CANONICAL_NAN);
        end
        drain();
        total++;
        if (errOut !== 1'b0) begin
            bad++;
            $display("FAIL err_before_spurious: got %b, required 0", errOut);
        end
        #2 spur_req++;
        repeat (2) @(negedge clkIn);
        total++;
        if (errOut !== 1'b1) begin
            bad++;
            $display("FAIL err_set: got %b, required 1", errOut);
        end
        repeat (5) @(negedge clkIn);
        total++;
        if (errOut !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: got %b, required 1", errOut);
        end
    endtask

    task automatic test_reset_inflight();
        int pulses = 0;
        @(negedge clkIn);
        set_req(0, 2'b00, F1, F2);
        set_req(1, 2'b10, F2, F3);
        run_reqs();
        #2 rstIn = 1'b1;
        #1;
        total++;
        if (respValidOut !== '0 || respDataOut !== '0 || addValidOut !== 1'b0 ||
            mulValidOut !== 1'b0 || errOut !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_outputs: got rv=%b d=%h av=%b mv=%b err=%b, required 0",
                     respValidOut, respDataOut, addValidOut, mulValidOut, errOut);
        end
        total++;
        if (addAOut !== '0 || addBOut !== '0 || mulAOut !== '0 || mulBOut !== '0 ||
            reqReadyOut !== '0) begin
            bad++;
            $display("FAIL async_reset_operands: got %h %h %h %h rdy=%b, required 0",
                     addAOut, addBOut, mulAOut, mulBOut, reqReadyOut);
        end
        exp_q[0].delete();
        exp_q[1].delete();
        repeat (2) @(negedge clkIn);
        rstIn = 1'b0;
        repeat (10) begin
            @(negedge clkIn);
            if (respValidOut != '0) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL reset_abandon: got %0d response cycles, required 0", pulses);
        end
        @(negedge clkIn);
        set_req(0, 2'b00, F3, NEG1);
        run_reqs();
        drain();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int rc;
        @(negedge clkIn);
        set_req(0, 2'b00, F1, F2);
        run_reqs();
        while (!respValidOut[0] && n < 20) begin
            @(negedge clkIn);
            n++;
        end
        total++;
        if (!respValidOut[0]) begin
            bad++;
            $display("FAIL b2b_resp_timeout: got no response, required one within 20 cycles");
        end else begin
            rc = cyc;
            set_req(0, 2'b10, F2, F3);
            #1;
            total++;
            if (reqReadyOut[0] !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready: got %b in response cycle, required 1", reqReadyOut[0]);
            end
            run_reqs();
            total++;
            if (grant_cyc[0] != rc) begin
                bad++;
                $display("FAIL b2b_grant_cycle: got %0d, required %0d", grant_cyc[0], rc);
            end
        end
        drain();
    endtask

    initial begin
        rstIn      = 1'b1;
        reqValidIn = '0;
        for (int i = 0; i < NR; i++) begin
            r_op[i]      = 2'b00;
            r_a[i]       = '0;
            r_b[i]       = '0;
            last_resp[i] = -1;
            grant_cyc[i] = -1;
        end
        fork
            unit_model();
            monitor();
        join_none
        test_reset();
        test_add();
        test_sub();
        test_round_robin();
        test_same_cycle();
        test_illegal();
        test_reset_inflight();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

endmodule
